// File: rtl/sqwave_pkg.sv
// ---------------------------------------------------------------------------
// sqwave_pkg
//   Definitions shared by square_wave_gen and square_wave_meas.
//   TICK_DIV     : clocks per 100 ns measurement unit at 100 MHz
//   meas_state_t : measurement FSM states
// ---------------------------------------------------------------------------
package sqwave_pkg;

    localparam int TICK_DIV = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous pin into the i_clk domain through SYNC_STAGES
//   flip-flops, then compares against a one-cycle-delayed copy to flag edges.
//   Ports:
//     i_clk   : system clock
//     i_rst   : synchronous reset, active-high (clears all flops to 0)
//     i_d     : asynchronous input
//     o_level : synchronized level
//     o_rise  : one-cycle pulse on a synchronized 0->1 transition
//     o_fall  : one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_d};
        prev_d  = sync_q[SYNC_STAGES-1];
        o_level = sync_q[SYNC_STAGES-1];
        o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
        o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/square_wave_meas.sv
// ---------------------------------------------------------------------------
// square_wave_meas
//   Measures the high time (o_m) and low time (o_n) of an incoming square
//   wave in units of TICK_DIV clocks. A complete high+low period is reported
//   at the rise that ends it, together with a one-cycle o_valid pulse.
//   Ports:
//     i_clk   : system clock
//     i_rst   : synchronous reset, active-high
//     i_sig   : square wave, asynchronous to i_clk
//     o_m     : last measured high time in units
//     o_n     : last measured low time in units
//     o_valid : one-cycle pulse when o_m/o_n update
//     o_err   : sticky overflow / zero-width error, cleared with next o_valid
// ---------------------------------------------------------------------------
module square_wave_meas
    import sqwave_pkg::*;
#(
    parameter int TICK_DIV    = sqwave_pkg::TICK_DIV,
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_sig,
    output logic [W-1:0] o_m,
    output logic [W-1:0] o_n,
    output logic         o_valid,
    output logic         o_err
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    // The edge cycle itself counts as the first clock of the new level, so
    // the prescaler restarts at 1. A level of D clocks then yields exactly
    // floor(D/TICK_DIV) ticks before the next edge.
    localparam logic [PRE_W-1:0] PRE_RESTART = (TICK_DIV > 1) ? PRE_W'(1) : '0;
    localparam logic [W-1:0]     CNT_MAX     = '1;

    logic sig_level;
    logic sig_rise;
    logic sig_fall;
    logic sig_edge;
    logic tick;
    logic overflow;

    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [W-1:0]     cnt_q,   cnt_d;
    logic [W-1:0]     hi_q,    hi_d;
    logic [W-1:0]     m_q,     m_d;
    logic [W-1:0]     n_q,     n_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;
    meas_state_t      state_q, state_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_sig),
        .o_level (sig_level),
        .o_rise  (sig_rise),
        .o_fall  (sig_fall)
    );

    // Prescaler and unit counter: an edge restarts both and suppresses tick.
    always_comb begin
        sig_edge = sig_rise | sig_fall;
        tick     = (pre_q == PRE_LAST) && !sig_edge;
        overflow = tick && (cnt_q == CNT_MAX);

        if (sig_edge) begin
            pre_d = PRE_RESTART;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        if (sig_edge) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Measurement FSM. The synchronized level after an edge tells which edge
    // arrived; edges only alternate, so in S_HIGH a level-low edge is a fall.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        m_d     = m_q;
        n_d     = n_q;
        valid_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (sig_rise) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (sig_edge && !sig_level) begin
                    if (cnt_q == '0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hi_d    = cnt_q;
                        state_d = S_LOW;
                    end
                end else if (overflow) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LOW: begin
                if (sig_edge && sig_level) begin
                    if (cnt_q == '0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        m_d     = hi_q;
                        n_d     = cnt_q;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        // This rise also starts the next high phase.
                        state_d = S_HIGH;
                    end
                end else if (overflow) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            m_q     <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            m_q     <= m_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign o_m     = m_q;
    assign o_n     = n_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule
